// File: rtl/router_pkg.sv
// Shared state encoding and parameter defaults for the packet router control FSM.
package router_pkg;

    localparam int NUM_PORTS_DEF = 3;
    localparam int ADDR_W_DEF    = 2;
    localparam int WAIT_MAX_DEF  = 255;

    typedef enum logic [3:0] {
        S_DA   = 4'd0,
        S_LFD  = 4'd1,
        S_LD   = 4'd2,
        S_FFS  = 4'd3,
        S_LAF  = 4'd4,
        S_LP   = 4'd5,
        S_CPE  = 4'd6,
        S_WTE  = 4'd7,
        S_DROP = 4'd8
    } state_t;

endpackage

// File: rtl/router_wait_timer.sv
// Counts cycles spent waiting for a destination FIFO to drain; expire fires on the
// enabled cycle that completes WAIT_MAX waiting cycles (WAIT_MAX = 0 never expires).
module router_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    logic [CW-1:0] count;

    assign expire = enable && (WAIT_MAX != 0) && (count == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            count <= '0;
        else if (clear || expire)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/router_fsm_np.sv
// Router control FSM: decodes the header, sequences FIFO loading around full/parity
// events, waits for a busy destination to drain and drops unroutable packets.
module router_fsm_np
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int WAIT_MAX  = WAIT_MAX_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    output logic                 write_enb_reg,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 laf_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic                 drop_pkt,
    output logic [ADDR_W-1:0]    dest_addr,
    output logic                 wait_timeout
);

    localparam int NA = 2 ** ADDR_W;

    state_t state, next;
    logic   timeout_d, expire, addr_ok;

    // Widened so any address indexes safely; nonexistent ports read as not-empty / no reset.
    logic [NA-1:0] empty_ext, srst_ext;
    assign empty_ext = NA'(fifo_empty);
    assign srst_ext  = NA'(soft_reset);
    assign addr_ok   = 32'(data_in) < NUM_PORTS;

    router_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clock  (clock),
        .resetn (resetn),
        .clear  (state != S_WTE),
        .enable ((state == S_WTE) && !empty_ext[dest_addr]),
        .expire (expire)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_DA;
            dest_addr    <= '0;
            wait_timeout <= 1'b0;
        end else begin
            state        <= next;
            wait_timeout <= timeout_d;
            if (state == S_DA && pkt_valid)
                dest_addr <= data_in;
        end
    end

    always_comb begin
        next      = state;
        timeout_d = 1'b0;
        case (state)
            S_DA:
                if (pkt_valid) begin
                    if (!addr_ok)                 next = S_DROP;
                    else if (empty_ext[data_in])  next = S_LFD;
                    else                          next = S_WTE;
                end
            S_LFD:  next = S_LD;
            S_LD:
                if (fifo_full)       next = S_FFS;
                else if (!pkt_valid) next = S_LP;
            S_FFS:
                if (!fifo_full)      next = S_LAF;
            S_LAF:
                if (parity_done)           next = S_DA;
                else if (low_packet_valid) next = S_LP;
                else                       next = S_LD;
            S_LP:   next = S_CPE;
            S_CPE:  next = fifo_full ? S_FFS : S_DA;
            S_WTE:
                if (empty_ext[dest_addr]) next = S_LFD;
                else if (expire) begin
                    next      = S_DROP;
                    timeout_d = 1'b1;
                end
            S_DROP:
                if (!pkt_valid) next = S_DA;
            default: next = S_DA;
        endcase
        // A soft reset of the active port aborts the packet from any busy state.
        if (state != S_DA && srst_ext[dest_addr]) begin
            next      = S_DA;
            timeout_d = 1'b0;
        end
    end

    assign detect_add    = (state == S_DA);
    assign lfd_state     = (state == S_LFD);
    assign ld_state      = (state == S_LD);
    assign laf_state     = (state == S_LAF);
    assign full_state    = (state == S_FFS);
    assign rst_int_reg   = (state == S_CPE);
    assign drop_pkt      = (state == S_DROP);
    assign write_enb_reg = (state == S_LD) || (state == S_LP) || (state == S_LAF);
    assign busy          = (state != S_DA) && (state != S_LD);

endmodule

// File: doc/router_fsm_np.md
ROUTER_FSM_NP -- requirements
Module: router_fsm_np

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of destination FIFOs (legal 2..8).
REQ-002 SHALL have parameter ADDR_W, default 2, header address width; SHALL satisfy 2**ADDR_W >= NUM_PORTS.
REQ-003 SHALL have parameter WAIT_MAX, default 255, WAIT_TILL_EMPTY timeout in cycles; 0 disables the timeout.
REQ-004 clock  in  1  single clock, all state on rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 pkt_valid  in  1  packet byte valid from source.
REQ-007 data_in  in  ADDR_W  header address bits, sampled in DECODE_ADDRESS.
REQ-008 fifo_full  in  1  full flag of currently selected FIFO.
REQ-009 fifo_empty  in  NUM_PORTS  per-port empty flags.
REQ-010 soft_reset  in  NUM_PORTS  per-port soft-reset pulses.
REQ-011 parity_done  in  1  parity byte written.
REQ-012 low_packet_valid  in  1  pkt_valid fell while FIFO was full.
REQ-013 write_enb_reg, detect_add, lfd_state, laf_state, ld_state, full_state, rst_int_reg, busy  out  1 each  state-decoded controls.
REQ-014 drop_pkt  out  1  high in DROP state.
REQ-015 dest_addr  out  ADDR_W  latched destination of current packet.
REQ-016 wait_timeout  out  1  one-cycle pulse when WAIT_TILL_EMPTY times out.

Function
REQ-017 States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE), DROP.
REQ-018 DA: pkt_valid and data_in < NUM_PORTS and fifo_empty[data_in] -> LFD; pkt_valid, data_in < NUM_PORTS, not empty -> WTE; pkt_valid and data_in >= NUM_PORTS -> DROP; else stay.
REQ-019 dest_addr SHALL load data_in on every DA cycle with pkt_valid high and hold in all other states.
REQ-020 LFD -> LD unconditionally.
REQ-021 LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay.
REQ-022 FFS: !fifo_full -> LAF; else stay.
REQ-023 LAF: parity_done -> DA; else low_packet_valid -> LP; else -> LD.
REQ-024 LP -> CPE unconditionally; CPE: fifo_full -> FFS, else -> DA.
REQ-025 WTE: fifo_empty[dest_addr] -> LFD; else wait counter increments; counter reaching WAIT_MAX (WAIT_MAX != 0) -> DROP with wait_timeout pulse; counter clears on WTE entry.
REQ-026 DROP: stay while pkt_valid; !pkt_valid -> DA; no FIFO write.
REQ-027 soft_reset[dest_addr] high in any state except DA SHALL force next state DA, overriding all other transitions; soft_reset of other ports SHALL be ignored.
REQ-028 Outputs Moore-decoded from state register: detect_add=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE, drop_pkt=DROP.
REQ-029 write_enb_reg SHALL be high in LD, LP, LAF only.
REQ-030 busy SHALL be high in all states except DA and LD (high in DROP).

Reset
REQ-031 resetn low SHALL immediately set state DA, dest_addr 0, wait counter 0, wait_timeout 0; outputs thus detect_add=1, all others 0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; no output glitches beyond asynchronous clear.

Structure
REQ-033 State encoding (enumerated) and parameter defaults SHALL live in shared package router_pkg.
REQ-034 Wait counter SHALL be a sub-module router_wait_timer (clear, enable, WAIT_MAX parameter, expire pulse).

Verification
REQ-035 Reset then pkt_valid=1, data_in=0, fifo_empty=3'b111 -> DA,LFD,LD; pkt_valid=0 -> LP,CPE,DA; write_enb_reg high LD/LP only.
REQ-036 data_in=1, fifo_empty[1]=0 for 3 cycles then 1 -> WTE 3 cycles, LFD next; busy high throughout.
REQ-037 In LD, fifo_full=1 two cycles then 0 with parity_done=1 -> FFS,FFS,LAF,DA.
REQ-038 data_in=3 (NUM_PORTS=3), pkt_valid 4 cycles -> DROP 4 cycles, drop_pkt=1, write_enb_reg=0, then DA.
REQ-039 WAIT_MAX=4, fifo_empty[2]=0 held -> 4 WTE cycles, wait_timeout single pulse, DROP; soft_reset[2] in LD -> DA next cycle, soft_reset[0] in LD ignored.
REQ-040 resetn low mid-FFS (asynchronous, between edges) -> detect_add=1 immediately, dest_addr=0.
